// File: rtl/lut_pkg.sv
// Shared constants, FSM state encoding and count clamp for the branch-target table loader.
package lut_pkg;

    localparam int LUT_DEPTH = 32;
    localparam int TARGET_W  = 10;
    localparam int PTR_W     = 5;
    localparam int CNT_W     = 6;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4
    } lut_state_e;

    // Requests larger than the table are truncated to the table depth.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] count);
        logic [CNT_W-1:0] n;
        if (count > 6'd32) begin
            n = 6'd32;
        end else begin
            n = count;
        end
        return n;
    endfunction

endpackage

// File: rtl/lut_regfile.sv
// 32 x 10 branch-target storage: one synchronous write port, one asynchronous read port,
// cleared only by reset.
import lut_pkg::*;

module lut_regfile (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [PTR_W-1:0]    waddr,
    input  logic [TARGET_W-1:0] wdata,
    input  logic [PTR_W-1:0]    raddr,
    output logic [TARGET_W-1:0] rdata
);

    logic [TARGET_W-1:0] mem_r [LUT_DEPTH];

    // Storage array: cleared on reset, written one entry per accepted high byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                mem_r[i] <= {TARGET_W{1'b0}};
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/lut_loader.sv
// Byte-stream loader for the writable branch-target table with a combinational read port.
// Optional trailing XOR checksum byte is enabled by defining LUT_LOADER_CHECKSUM_EN.
import lut_pkg::*;

module lut_loader (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                Start,
    input  logic [CNT_W-1:0]    Count,
    input  logic [7:0]          Din,
    input  logic                DinValid,
    output logic                DinReady,
    input  logic [PTR_W-1:0]    addr,
    output logic [TARGET_W-1:0] Target,
    output logic                Busy,
    output logic                Done,
    output logic                Err
);

    lut_state_e         state_r;
    logic [CNT_W-1:0]   n_r;
    logic [CNT_W-1:0]   k_r;
    logic [CNT_W-1:0]   k_next_s;
    logic [7:0]         lo_r;
    logic               err_r;
    logic               we_s;
    logic [TARGET_W-1:0] wdata_s;
`ifdef LUT_LOADER_CHECKSUM_EN
    logic [7:0]         csum_r;
`endif

    assign k_next_s = k_r + 6'd1;
    assign we_s     = (state_r == HI) && DinValid;
    assign wdata_s  = {Din[1:0], lo_r};

    // Load sequencer: start handling, byte assembly, entry index, sticky error and checksum.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= IDLE;
            n_r     <= 6'd0;
            k_r     <= 6'd0;
            lo_r    <= 8'd0;
            err_r   <= 1'b0;
`ifdef LUT_LOADER_CHECKSUM_EN
            csum_r  <= 8'd0;
`endif
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (Start) begin
                        n_r   <= clamp_count(Count);
                        k_r   <= 6'd0;
                        err_r <= 1'b0;
`ifdef LUT_LOADER_CHECKSUM_EN
                        csum_r <= 8'd0;
`endif
                        state_r <= (clamp_count(Count) == 6'd0) ? DONE : LO;
                    end
                end
                LO: begin
                    if (DinValid) begin
                        lo_r    <= Din;
`ifdef LUT_LOADER_CHECKSUM_EN
                        csum_r  <= csum_r ^ Din;
`endif
                        state_r <= HI;
                    end
                end
                HI: begin
                    if (DinValid) begin
                        // Upper six bits of the high byte must be zero; entry is still written masked.
                        if (Din[7:2] != 6'd0) begin
                            err_r <= 1'b1;
                        end
                        k_r <= k_next_s;
`ifdef LUT_LOADER_CHECKSUM_EN
                        csum_r <= csum_r ^ Din;
                        state_r <= (k_next_s == n_r) ? CHK : LO;
`else
                        state_r <= (k_next_s == n_r) ? DONE : LO;
`endif
                    end
                end
`ifdef LUT_LOADER_CHECKSUM_EN
                CHK: begin
                    if (DinValid) begin
                        if (Din != csum_r) begin
                            err_r <= 1'b1;
                        end
                        state_r <= DONE;
                    end
                end
`endif
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign DinReady = (state_r == LO) || (state_r == HI) || (state_r == CHK);
    assign Busy     = DinReady;
    assign Done     = (state_r == DONE);
    assign Err      = err_r;

    lut_regfile u_regfile (
        .clk   (Clk),
        .rst_n (Reset_n),
        .we    (we_s),
        .waddr (k_r[PTR_W-1:0]),
        .wdata (wdata_s),
        .raddr (addr),
        .rdata (Target)
    );

endmodule

// File: doc/lut_loader.md
# lut_loader

Writable branch-target table for the CSE141L core and the write-side counterpart of the fixed branch-target lookup. It accepts a byte stream of 10-bit PC targets over a valid/ready handshake at program start and stores them in a 32-entry table. It exposes the same 5-bit pointer to 10-bit target read port, so one datapath serves programs 1–3 without rebuilding the lookup.

## Interface
- No parameters. Table depth 32 and target width 10 are package constants.
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  begin a load; sampled only in IDLE or DONE.
- Count  input  6  number of entries to load; latched on an accepted Start.
- Din  input  8  stream byte.
- DinValid  input  1  Din holds a valid byte.
- DinReady  output  1  the loader accepts a byte this cycle.
- addr  input  5  table read pointer.
- Target  output  10  combinational read of table[addr].
- Busy  output  1  a load is in progress.
- Done  output  1  the last load completed; held until the next accepted Start.
- Err  output  1  sticky format or checksum error for the current load.

## Operation
- States:
  - IDLE: entered on reset.
  - LO: waiting for the low byte.
  - HI: waiting for the high byte.
  - CHK: waiting for the checksum byte; exists only with the macro.
  - DONE: load complete.
- Start in IDLE or DONE:
  - Latch N = min(Count, 32).
  - Clear the entry index k, Err and the running checksum.
  - Clear Done.
  - Go to LO; if N = 0, go directly to DONE.
- Start while Busy is ignored.
- A beat transfers only when DinValid && DinReady. DinReady = 1 exactly in LO, HI and CHK.
- LO beat: register the byte as lo. Go to HI.
- HI beat:
  - Write table[k] <= {Din[1:0], lo}.
  - If Din[7:2] ≠ 0, set Err. The entry is still written with the masked bits.
  - k++.
  - If k reaches N, go to CHK (macro) or DONE; otherwise go to LO.
- Entries at index ≥ N keep their previous contents.
- A new load overwrites only its own entries. The table is cleared only by reset.
- Target = table[addr] at all times, including during a load.
- Busy = state ∈ {LO, HI, CHK}. Done = state == DONE.

## Timing
- Reset values:
  - DinReady = 0, Busy = 0, Done = 0, Err = 0.
  - State = IDLE, k = 0.
  - All table entries = 0, so Target = 0.
- Reset asserted mid-load returns everything to the reset values immediately (asynchronously).
- The cycle after an accepted Start has Busy = 1 and DinReady = 1. No byte is accepted in the Start cycle itself.
- Write latency: a HI beat at edge t makes the new value visible on Target after edge t. Reading the same address during the beat cycle returns the old value.
- Done rises on the edge that accepts the final byte (HI, or CHK with the macro).
- Minimum load time is 2N beats (2N+1 with checksum). DinValid gaps stall the FSM indefinitely with no timeout.
- Err is updated on the same edge as the offending beat.

## Configuration
- LUT_LOADER_CHECKSUM_EN defined:
  - Maintain a running XOR of all 2N data bytes.
  - After the last HI beat, go to CHK and accept one byte.
  - If that byte ≠ the running XOR, set Err. Then go to DONE.
  - With N = 0, no checksum byte is expected.
- Undefined: no CHK state and no checksum logic. The last HI beat goes directly to DONE.

## Structure
- Package lut_pkg holds:
  - LUT_DEPTH = 32, TARGET_W = 10, PTR_W = 5.
  - The state enum {IDLE, LO, HI, CHK, DONE}.
- One sub-module: lut_regfile, a 32×10 register array with one write port and one asynchronous read port, cleared on reset. The FSM, index counter and checksum live in lut_loader.

## Test plan
- Reset then read: addr = 0..31 → Target = 0 for all; DinReady = 0, Busy = 0, Done = 0.
- Full program-1 load, Count = 8, bytes 0x13,0x00,0x20,0x00,…,0x41,0x00 (plus checksum byte when enabled) → addr 4 reads 10'h03C, addr 7 reads 10'h041, addr 8 reads 0, Done = 1, Err = 0.
- High byte 0x06 for entry 0, Count = 1 → table[0] = {2'b10, lo}, Err = 1.
- Random DinValid gaps plus a Start pulse mid-load → loaded contents identical to the gap-free run; the mid-load Start is ignored.
- Count = 0 → Done = 1 one cycle after Start, no writes. Count = 40 → exactly 32 entries loaded.
- Macro on, wrong checksum byte → Err = 1, Done = 1, data entries still written. Reset_n low mid-load → all outputs and the table return to zero.
